// File: rtl/wshb_ram_slave.sv
// wshb_ram_slave: Wishbone classic slave backed by a pixel-word RAM.
// Pattern-filled after reset, programmable wait states, error on out-of-range.
module wshb_ram_slave #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           adr,
  input  logic [DATA_WIDTH-1:0] dat_ms,
  input  logic [1:0]            sel,
  input  logic                  we,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic [2:0]            cti,
  input  logic [1:0]            bte,
  output logic [DATA_WIDTH-1:0] dat_sm,
  output logic                  ack,
  output logic                  err,
  output logic                  rty,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] LAT = 3'(LATENCY);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] fill_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  we_q;
  logic                  oor_q;
  logic [1:0]            sel_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [DATA_WIDTH-1:0] mask;
  logic                  take;
  logic                  fill_last;
  logic                  resp_wr;
  logic                  resp_rd;
  logic                  unused_bits;

  assign unused_bits = ^{cti, bte, adr[0]};

  assign fill_last = (fill_q == '1);
  assign resp_wr   = (state_q == S_RESP) && we_q && !oor_q;
  assign resp_rd   = (state_q == S_RESP) && !we_q && !oor_q;

  assign ack = (state_q == S_RESP) && !oor_q;
  assign err = (state_q == S_RESP) && oor_q;
  assign rty = 1'b0;

  always_comb begin
    mask = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      mask[k] = (k < 8) ? sel_q[0] : sel_q[1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (fill_last) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cyc && stb) begin
          take = 1'b1;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      S_WAIT: begin
        // a dropped strobe abandons the access silently
        if (!(cyc && stb)) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd1) begin
          state_d = S_RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      fill_q    <= '0;
      init_done <= 1'b0;
      dat_sm    <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      sel_q     <= '0;
      wd_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_INIT) begin
        fill_q <= fill_q + 1'b1;
        if (fill_last) init_done <= 1'b1;
      end
      if (take) begin
        idx_q <= adr[ADDR_WIDTH:1];
        oor_q <= |adr[31:ADDR_WIDTH+1];
        we_q  <= we;
        sel_q <= sel;
        wd_q  <= dat_ms;
      end
      if (resp_rd) dat_sm <= mem[idx_q];
    end
  end

  // no reset on the array itself; INIT rewrites every word
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT) begin
        mem[fill_q] <= DATA_WIDTH'(fill_q);
      end else if (resp_wr) begin
        mem[idx_q] <= (mem[idx_q] & ~mask) | (wd_q & mask);
      end
    end
  end

endmodule

// File: tb/tb_wshb_ram_slave.sv
// tb_wshb_ram_slave: directed checks of fill, reads, lane writes,
// error range, back-to-back strobes, aborts and mid-transaction reset.
module tb_wshb_ram_slave;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [15:0] dat_ms;
  logic [1:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [15:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  wshb_ram_slave #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(10),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .adr(adr),
    .dat_ms(dat_ms),
    .sel(sel),
    .we(we),
    .cyc(cyc),
    .stb(stb),
    .cti(cti),
    .bte(bte),
    .dat_sm(dat_sm),
    .ack(ack),
    .err(err),
    .rty(rty),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input  logic [31:0] a,
                      input  logic        w,
                      input  logic [1:0]  s,
                      input  logic [15:0] d,
                      output logic        t_ack,
                      output logic        t_err,
                      output int          lat,
                      output logic        ack_after,
                      output logic        err_after,
                      output logic [15:0] rd);
    adr = a; we = w; sel = s; dat_ms = d;
    cyc = 1'b1; stb = 1'b1;
    t_ack = 1'b0; t_err = 1'b0; lat = 0;
    @(posedge clk);
    while (lat < 16) begin
      @(negedge clk);
      lat++;
      if (ack || err) begin
        t_ack = ack;
        t_err = err;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    ack_after = ack;
    err_after = err;
    rd = dat_sm;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [15:0] exp);
    logic ta, te, aa, ea;
    logic [15:0] rd;
    int lat;
    xfer(a, 1'b0, 2'b11, 16'h0, ta, te, lat, aa, ea, rd);
    chk({tag, "_ack"}, 32'(ta), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, 32'(rd), 32'(exp));
  endtask

  task automatic wr_chk(input string tag,
                        input logic [31:0] a,
                        input logic [1:0] s,
                        input logic [15:0] d,
                        input logic [15:0] prev_rd);
    logic ta, te, aa, ea;
    logic [15:0] rd;
    int lat;
    xfer(a, 1'b1, s, d, ta, te, lat, aa, ea, rd);
    chk({tag, "_ack"}, 32'(ta), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_pulse"}, 32'(aa), 32'd0);
    chk({tag, "_dat_sm_held"}, 32'(rd), 32'(prev_rd));
  endtask

  task automatic wait_init(output int n, output logic term);
    n = 0;
    term = 1'b0;
    while (n < 1100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack || err) term = 1'b1;
      if (init_done) break;
    end
  endtask

  initial begin
    int n, m;
    logic term, ta, te, aa, ea;
    logic [15:0] rd;
    logic [15:0] ack_vec;
    logic [15:0] exp_vec;

    rst = 1'b1; adr = '0; dat_ms = '0; sel = 2'b11;
    we = 1'b0; cyc = 1'b0; stb = 1'b0; cti = 3'd0; bte = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dat", 32'(dat_sm), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rty", 32'(rty), 32'd0);

    // request pending throughout the fill
    rst = 1'b0;
    adr = 32'd10; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
    wait_init(n, term);
    chk("init_cycles", 32'(n), 32'd1024);
    chk("init_no_term", 32'(term), 32'd0);
    m = 0;
    while (m < 10) begin
      @(negedge clk);
      m++;
      if (ack || err) break;
    end
    chk("init_req_lat", 32'(m), 32'd3);
    chk("init_req_ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("init_req_pulse", 32'(ack), 32'd0);
    chk("init_req_data", 32'(dat_sm), 32'h0005);

    rd_chk("rd0", 32'd0, 16'h0000);
    rd_chk("rd5", 32'd10, 16'h0005);
    rd_chk("rd1023", 32'd2046, 16'h03FF);

    wr_chk("wr_sel01", 32'd20, 2'b01, 16'hBEEF, 16'h03FF);
    rd_chk("rd_sel01", 32'd20, 16'h00EF);
    wr_chk("wr_sel10", 32'd20, 2'b10, 16'hBEEF, 16'h00EF);
    rd_chk("rd_sel10", 32'd20, 16'hBEEF);
    wr_chk("wr_sel00", 32'd20, 2'b00, 16'h1234, 16'hBEEF);
    rd_chk("rd_sel00", 32'd20, 16'hBEEF);

    xfer(32'h0000_0800, 1'b0, 2'b11, 16'h0, ta, te, n, aa, ea, rd);
    chk("oor_rd_err", 32'(te), 32'd1);
    chk("oor_rd_noack", 32'(ta), 32'd0);
    chk("oor_rd_lat", 32'(n), 32'd3);
    chk("oor_rd_pulse", 32'(ea), 32'd0);
    chk("oor_rd_dat_held", 32'(rd), 32'hBEEF);
    xfer(32'h0000_0800, 1'b1, 2'b11, 16'h1234, ta, te, n, aa, ea, rd);
    chk("oor_wr_err", 32'(te), 32'd1);
    chk("oor_wr_noack", 32'(ta), 32'd0);
    rd_chk("oor_wr_word0", 32'd0, 16'h0000);

    // four reads with stb held: ack on cycles 3, 7, 11, 15
    adr = 32'd6; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
    ack_vec = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ack_vec[k] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    exp_vec = 16'b0100_0100_0100_0100;
    chk("b2b_ack_pattern", 32'(ack_vec), 32'(exp_vec));
    @(negedge clk);
    chk("b2b_data", 32'(dat_sm), 32'h0003);

    adr = 32'd40; we = 1'b1; sel = 2'b11; dat_ms = 16'h5555;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    term = ack || err;
    stb = 1'b0;
    repeat (6) begin
      @(negedge clk);
      term = term || ack || err;
    end
    cyc = 1'b0;
    chk("abort_no_term", 32'(term), 32'd0);
    rd_chk("abort_word20", 32'd40, 16'h0014);

    wr_chk("wr_w3", 32'd6, 2'b11, 16'hFFFF, 16'h0014);
    rd_chk("rd_w3", 32'd6, 16'hFFFF);
    adr = 32'd6; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    wait_init(n, term);
    chk("reinit_cycles", 32'(n), 32'd1024);
    chk("reinit_no_term", 32'(term), 32'd0);
    rd_chk("refill_w3", 32'd6, 16'h0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wshb_ram_slave.md
# wshb_ram_slave

Wishbone classic slave holding a pixel-word memory, serving the reads issued by the display path's Wishbone master, plus writes. It is the responder end of the `wshb_if` link and stands in for the SDRAM controller in simulation and small-frame builds. After reset it fills its memory with a known pattern, then answers single-word transactions with a programmable number of wait states. Out-of-range accesses get an error response.

## Interface
- `DATA_WIDTH`, 16: word width. RGB565 pixel.
- `ADDR_WIDTH`, 10: word-index width. Depth = 2**ADDR_WIDTH words.
- `LATENCY`, 2: read/write wait states, range 0..7.
- `clk`  in  1: sole clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `adr`  in  32: byte address. The word index is `adr[ADDR_WIDTH:1]`. `adr[0]` is ignored.
- `dat_ms`  in  DATA_WIDTH: write data from the master.
- `sel`  in  2: byte lane enables. `sel[1]` = bits 15:8, `sel[0]` = bits 7:0.
- `we`  in  1: 1 = write, 0 = read.
- `cyc`, `stb`  in  1 each: bus cycle and strobe.
- `cti`, `bte`  in  3, 2: accepted and ignored. Classic cycles only.
- `dat_sm`  out  DATA_WIDTH: read data.
- `ack`  out  1: normal termination.
- `err`  out  1: error termination.
- `rty`  out  1: tied to 0.
- `init_done`  out  1: high once the memory pattern fill has completed.

## Operation
- States:
  - INIT: fill memory.
  - IDLE: wait for a request.
  - WAIT: count wait states.
  - RESP: terminate the transaction.
- INIT
  - Entered on reset.
  - A counter `i` steps 0..2**ADDR_WIDTH-1, one word per cycle, writing word[i] = i zero-extended/truncated to DATA_WIDTH.
  - After the last word: go to IDLE and set `init_done` = 1. It stays 1 until the next reset.
  - Requests during INIT are stalled: no `ack`, no `err`. They are serviced once IDLE is reached.
- IDLE
  - On `cyc & stb`, latch `adr`, `we`, `sel`, `dat_ms`.
  - Range check: the access is out of range when `adr[31:ADDR_WIDTH+1] != 0`.
  - Next state: RESP if LATENCY = 0, otherwise WAIT with wait counter = LATENCY.
- WAIT
  - Decrement the counter each cycle.
  - Go to RESP on the cycle the counter reaches 1 before decrementing.
  - If `cyc` or `stb` is low in any WAIT cycle: abort to IDLE. No termination, no memory change.
- RESP, one cycle only, then IDLE
  - In range: assert `ack` = 1.
    - Read: `dat_sm` = word[index].
    - Write: update word[index] per byte lane, only lanes with `sel` bit = 1. `sel` = 00 still acks and changes nothing.
  - Out of range: assert `err` = 1 instead of `ack`. No write. `dat_sm` unchanged.
- `dat_sm` holds its last read value outside RESP. Writes never change `dat_sm`.
- Latched request fields are used throughout. Master input changes after IDLE sampling do not affect the transaction, except aborts.

## Timing
- Reset values: `ack` = 0, `err` = 0, `dat_sm` = 0, `init_done` = 0, `rty` = 0. State is INIT, fill counter 0.
- Reset asserted mid-INIT or mid-transaction: back to INIT on the next edge.
  - Any pending transaction is dropped without termination.
  - The whole memory is refilled.
- Init duration: `init_done` rises 2**ADDR_WIDTH cycles after the first cycle with `rst` low.
- Latency: request sampled in IDLE at edge t gives `ack`/`err` high in cycle t+1+LATENCY. The termination pulse is exactly 1 cycle wide.
- Throughput with `stb` held high: one termination every LATENCY+2 cycles. After RESP, IDLE re-samples the still-asserted request on the next edge.
- `ack` and `err` are never high together, and never high outside RESP.
- Write then read of the same word: the read returns the new data. The write commits at the RESP edge, before the next IDLE sample.

## Test plan
- Reset, wait for `init_done`, read index 0, 5 and 1023 (adr 0, 10, 2046) -> `dat_sm` = 0x0000, 0x0005, 0x03FF; each `ack` exactly 3 cycles after the sampling edge (LATENCY = 2).
- Write 0xBEEF to adr 20 with `sel` = 01, then read adr 20 -> 0x00EF. Write 0xBEEF with `sel` = 10, read -> 0xBEEF. Write with `sel` = 00 -> `ack` received, data unchanged.
- Read adr 0x0000_0800 (index 1024) -> `err` pulse 1 cycle, no `ack`, `dat_sm` keeps previous value. Write there -> `err`, and memory index 0 is still 0x0000.
- `stb` held high for 4 reads at LATENCY = 2 -> `ack` every 4 cycles; no two adjacent `ack` cycles.
- Drop `stb` during WAIT on a write to adr 40 -> no `ack`, word 20 still 0x0014. Request issued during INIT -> no termination until after `init_done`, then `ack` after LATENCY+1 cycles.
- Assert `rst` during WAIT after writing 0xFFFF to word 3 -> `ack`/`init_done` drop to 0, pending transaction dropped, `init_done` returns after 1024 cycles, word 3 reads 0x0003.
